adpll_cfg_seq: RTL and testbench



---
 rtl/adpll_cfg_seq.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_adpll_cfg_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adpll_cfg_seq.sv
// ----------------------------------------------------------------------------
// adpll_cfg_seq
// Bus-initiator sequencer that brings up one ADPLL channel through the
// adpll_ctr register slave. An accepted start runs the access sequence
//   SOFT_RST<-1, SOFT_RST<-0, FCW<-fcw, MODE<-mode, EN<-1,
//   poll LOCK (with POLL_GAP idle cycles between polls), read SAT
// and reports the outcome. A lock timeout writes EN<-0 before finishing;
// a bus timeout or decode error finishes immediately.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           one-cycle request, honoured only in IDLE
//   i_fcw_in          frequency control word, captured on accepted start
//   i_mode_in         ADPLL mode, captured on accepted start
//   o_busy            sequence in progress
//   o_done            one-cycle end-of-sequence pulse
//   o_locked, o_sat   result flags, held until the next accepted start
//   o_err_bus         bus timeout or decode error, held
//   o_err_lock        lock timeout, held
//   o_valid .. o_wstrb  master side of the register access port
//   i_rdata, i_ready  slave response
// ----------------------------------------------------------------------------
module adpll_cfg_seq #(
  parameter int FCWW         = 26,
  parameter int ADPLL_ADDR_W = 4,
  parameter int ADPLL_DATA_W = 32,
  parameter int LOCK_TO      = 4096,
  parameter int POLL_GAP     = 16,
  parameter int BUS_TO       = 8,
  parameter logic [ADPLL_ADDR_W-1:0] ADPLL_SOFT_RST = 4'h0,
  parameter logic [ADPLL_ADDR_W-1:0] ADPLL_FCW      = 4'h1,
  parameter logic [ADPLL_ADDR_W-1:0] ADPLL_MODE     = 4'h2,
  parameter logic [ADPLL_ADDR_W-1:0] ADPLL_EN       = 4'h3,
  parameter logic [ADPLL_ADDR_W-1:0] ADPLL_LOCK     = 4'h4,
  parameter logic [ADPLL_ADDR_W-1:0] ADPLL_SAT      = 4'h5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [FCWW-1:0]         i_fcw_in,
  input  logic [1:0]              i_mode_in,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_locked,
  output logic                    o_sat,
  output logic                    o_err_bus,
  output logic                    o_err_lock,
  output logic                    o_valid,
  output logic [ADPLL_ADDR_W-1:0] o_address,
  output logic [ADPLL_DATA_W-1:0] o_wdata,
  output logic                    o_wstrb,
  input  logic [1:0]              i_rdata,
  input  logic                    i_ready
);

  localparam int BCW = (BUS_TO > 1) ? $clog2(BUS_TO) : 1;
  localparam int PCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int LCW = $clog2(LOCK_TO + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_W_RST1, S_W_RST0, S_W_FCW, S_W_MODE, S_W_EN,
    S_R_LOCK, S_P_WAIT, S_R_SAT, S_W_DIS, S_GAP, S_FIN
  } state_t;

  state_t                  r_state;
  state_t                  r_nxt;      // state entered when S_GAP expires
  logic [FCWW-1:0]         r_fcw;
  logic [1:0]              r_mode;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_locked;
  logic                    r_sat;
  logic                    r_err_bus;
  logic                    r_err_lock;
  logic                    r_valid;
  logic [ADPLL_ADDR_W-1:0] r_address;
  logic [ADPLL_DATA_W-1:0] r_wdata;
  logic                    r_wstrb;
  logic [BCW-1:0]          r_bcnt;     // cycles spent waiting for ready
  logic [PCW-1:0]          r_pcnt;     // idle cycles spent in P_WAIT
  logic [LCW-1:0]          r_lcnt;     // cycles since the first lock poll
  logic                    r_lrun;     // lock timeout counter is running
  logic                    w_lexp;

  assign w_lexp = (r_lcnt == LCW'(LOCK_TO));

  // Register address targeted by an access state.
  function automatic logic [ADPLL_ADDR_W-1:0] f_addr(input state_t s);
    case (s)
      S_W_RST1, S_W_RST0: f_addr = ADPLL_SOFT_RST;
      S_W_FCW:            f_addr = ADPLL_FCW;
      S_W_MODE:           f_addr = ADPLL_MODE;
      S_W_EN, S_W_DIS:    f_addr = ADPLL_EN;
      S_R_LOCK:           f_addr = ADPLL_LOCK;
      S_R_SAT:            f_addr = ADPLL_SAT;
      default:            f_addr = {ADPLL_ADDR_W{1'b0}};
    endcase
  endfunction

  // Write data of an access state; reads and clearing writes carry zero.
  function automatic logic [ADPLL_DATA_W-1:0] f_wdata(input state_t s,
                                                      input logic [FCWW-1:0] fcw,
                                                      input logic [1:0] mode);
    case (s)
      S_W_RST1: f_wdata = ADPLL_DATA_W'(1'b1);
      S_W_FCW:  f_wdata = ADPLL_DATA_W'(fcw);
      S_W_MODE: f_wdata = ADPLL_DATA_W'(mode);
      S_W_EN:   f_wdata = ADPLL_DATA_W'(1'b1);
      default:  f_wdata = {ADPLL_DATA_W{1'b0}};
    endcase
  endfunction

  // 1 for write accesses, 0 for reads.
  function automatic logic f_is_wr(input state_t s);
    case (s)
      S_R_LOCK, S_R_SAT: f_is_wr = 1'b0;
      default:           f_is_wr = 1'b1;
    endcase
  endfunction

  // Successor of a write access in the fixed bring-up order.
  function automatic state_t f_next(input state_t s);
    case (s)
      S_W_RST1: f_next = S_W_RST0;
      S_W_RST0: f_next = S_W_FCW;
      S_W_FCW:  f_next = S_W_MODE;
      S_W_MODE: f_next = S_W_EN;
      S_W_EN:   f_next = S_R_LOCK;
      default:  f_next = S_FIN;
    endcase
  endfunction

  // Sequencer FSM with registered bus and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_nxt      <= S_IDLE;
      r_fcw      <= {FCWW{1'b0}};
      r_mode     <= 2'b00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_locked   <= 1'b0;
      r_sat      <= 1'b0;
      r_err_bus  <= 1'b0;
      r_err_lock <= 1'b0;
      r_valid    <= 1'b0;
      r_address  <= {ADPLL_ADDR_W{1'b0}};
      r_wdata    <= {ADPLL_DATA_W{1'b0}};
      r_wstrb    <= 1'b0;
      r_bcnt     <= {BCW{1'b0}};
      r_pcnt     <= {PCW{1'b0}};
      r_lcnt     <= {LCW{1'b0}};
      r_lrun     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Saturating lock timer; R_LOCK, P_WAIT and the gaps between them all count.
      if (r_lrun && !w_lexp) begin
        r_lcnt <= r_lcnt + LCW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_fcw      <= i_fcw_in;
            r_mode     <= i_mode_in;
            r_busy     <= 1'b1;
            r_locked   <= 1'b0;
            r_sat      <= 1'b0;
            r_err_bus  <= 1'b0;
            r_err_lock <= 1'b0;
            r_lrun     <= 1'b0;
            r_lcnt     <= {LCW{1'b0}};
            // The first access is launched through S_GAP like every other one.
            r_nxt      <= S_W_RST1;
            r_state    <= S_GAP;
          end
        end

        // One bus-idle cycle; on exit the next access is put on the bus.
        S_GAP: begin
          r_state <= r_nxt;
          if (r_nxt == S_FIN) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end else begin
            r_valid   <= 1'b1;
            r_address <= f_addr(r_nxt);
            r_wdata   <= f_wdata(r_nxt, r_fcw, r_mode);
            r_wstrb   <= f_is_wr(r_nxt);
            r_bcnt    <= {BCW{1'b0}};
            if (r_nxt == S_R_LOCK && !r_lrun) begin
              r_lrun <= 1'b1;
              r_lcnt <= {LCW{1'b0}};
            end
          end
        end

        S_P_WAIT: begin
          if (w_lexp) begin
            r_err_lock <= 1'b1;
            r_lrun     <= 1'b0;
            r_nxt      <= S_W_DIS;
            r_state    <= S_GAP;
          end else if (r_pcnt == PCW'(POLL_GAP - 1)) begin
            r_nxt   <= S_R_LOCK;
            r_state <= S_GAP;
          end else begin
            r_pcnt <= r_pcnt + PCW'(1);
          end
        end

        S_FIN: begin
          r_state <= S_IDLE;
        end

        S_W_RST1, S_W_RST0, S_W_FCW, S_W_MODE, S_W_EN, S_W_DIS, S_R_LOCK, S_R_SAT: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_state <= S_GAP;
            case (r_state)
              S_R_LOCK: begin
                if (i_rdata[1]) begin
                  // Unmapped status pattern: abort without further accesses.
                  r_err_bus <= 1'b1;
                  r_lrun    <= 1'b0;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_FIN;
                end else if (i_rdata[0]) begin
                  // Lock wins even if the timer expired during this read.
                  r_lrun <= 1'b0;
                  r_nxt  <= S_R_SAT;
                end else if (w_lexp) begin
                  r_err_lock <= 1'b1;
                  r_lrun     <= 1'b0;
                  r_nxt      <= S_W_DIS;
                end else begin
                  r_pcnt  <= {PCW{1'b0}};
                  r_state <= S_P_WAIT;
                end
              end
              S_R_SAT: begin
                if (i_rdata[1]) begin
                  r_err_bus <= 1'b1;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_FIN;
                end else begin
                  r_sat    <= i_rdata[0];
                  r_locked <= 1'b1;
                  r_nxt    <= S_FIN;
                end
              end
              default: begin
                r_nxt <= f_next(r_state);
              end
            endcase
          end else if (r_bcnt == BCW'(BUS_TO - 1)) begin
            // Slave never answered: drop the request and finish.
            r_valid   <= 1'b0;
            r_err_bus <= 1'b1;
            r_lrun    <= 1'b0;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_FIN;
          end else begin
            r_bcnt <= r_bcnt + BCW'(1);
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_locked   = r_locked;
  assign o_sat      = r_sat;
  assign o_err_bus  = r_err_bus;
  assign o_err_lock = r_err_lock;
  assign o_valid    = r_valid;
  assign o_address  = r_address;
  assign o_wdata    = r_wdata;
  assign o_wstrb    = r_wstrb;

endmodule

// File: tb/tb_adpll_cfg_seq.sv
// ----------------------------------------------------------------------------
// tb_adpll_cfg_seq
// Drives adpll_cfg_seq against a model adpll_ctr slave (ready two edges after
// valid rises, programmable lock behaviour, optional withheld ready) and
// compares the observed access log and status flags with an expected log
// built from the bring-up rules.
// ----------------------------------------------------------------------------
module tb_adpll_cfg_seq;

  localparam int FCWW     = 26;
  localparam int AW       = 4;
  localparam int DW       = 32;
  localparam int LOCK_TO  = 200;
  localparam int POLL_GAP = 16;
  localparam int BUS_TO   = 8;
  localparam logic [3:0] A_SR   = 4'h0;
  localparam logic [3:0] A_FCW  = 4'h1;
  localparam logic [3:0] A_MODE = 4'h2;
  localparam logic [3:0] A_EN   = 4'h3;
  localparam logic [3:0] A_LOCK = 4'h4;
  localparam logic [3:0] A_SAT  = 4'h5;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [FCWW-1:0] fcw_in;
  logic [1:0]      mode_in;
  logic            busy, done, locked, sat, err_bus, err_lock, valid, wstrb;
  logic [AW-1:0]   address;
  logic [DW-1:0]   wdata;
  logic [1:0]      rdata = 2'b00;
  logic            ready = 1'b0;

  always #5 clk = ~clk;

  adpll_cfg_seq #(
    .FCWW(FCWW), .ADPLL_ADDR_W(AW), .ADPLL_DATA_W(DW),
    .LOCK_TO(LOCK_TO), .POLL_GAP(POLL_GAP), .BUS_TO(BUS_TO),
    .ADPLL_SOFT_RST(A_SR), .ADPLL_FCW(A_FCW), .ADPLL_MODE(A_MODE),
    .ADPLL_EN(A_EN), .ADPLL_LOCK(A_LOCK), .ADPLL_SAT(A_SAT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_fcw_in(fcw_in), .i_mode_in(mode_in),
    .o_busy(busy), .o_done(done), .o_locked(locked), .o_sat(sat),
    .o_err_bus(err_bus), .o_err_lock(err_lock), .o_valid(valid),
    .o_address(address), .o_wdata(wdata), .o_wstrb(wstrb),
    .i_rdata(rdata), .i_ready(ready)
  );

  // Slave configuration (written by the stimulus only).
  logic sl_clr = 1'b1;
  int   cfg_npolls = 0;
  bit   cfg_never = 1'b0;
  bit   cfg_dec = 1'b0;
  bit   cfg_sat = 1'b0;
  int   cfg_hold = -1;

  // Slave / monitor state (written by the slave process only).
  logic [36:0] log_q[$];
  int sl_cnt = 0, acc_n = 0, lock_n = 0, lo_run = 0, hi_run = 0, last_hi = 0;
  int min_gap = 1000, t_cyc = 0, t_first = -1, t_done = -1, dcnt = 0;
  bit hold = 1'b0;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Model slave plus monitor, acting on the falling edge.
  always @(negedge clk) begin
    t_cyc <= t_cyc + 1;
    if (sl_clr) begin
      log_q.delete();
      sl_cnt <= 0; acc_n <= 0; lock_n <= 0; lo_run <= 0; hi_run <= 0; last_hi <= 0;
      min_gap <= 1000; t_first <= -1; t_done <= -1; dcnt <= 0; hold <= 1'b0;
      ready <= 1'b0; rdata <= 2'b00;
    end else begin
      if (done) begin
        dcnt   <= dcnt + 1;
        t_done <= t_cyc;
      end
      if (valid) begin
        lo_run <= 0;
        hi_run <= hi_run + 1;
        if (sl_cnt == 0) begin
          acc_n  <= acc_n + 1;
          hold   <= (acc_n == cfg_hold);
          sl_cnt <= 1;
          if (t_first < 0) t_first <= t_cyc;
          if (!wstrb && address == A_LOCK && lock_n > 0 && lo_run < min_gap) min_gap <= lo_run;
        end else if (sl_cnt == 1 && !hold) begin
          sl_cnt <= 2;
          ready  <= 1'b1;
          log_q.push_back({wstrb, address, wstrb ? wdata : 32'h0});
          if (!wstrb && address == A_LOCK) begin
            lock_n <= lock_n + 1;
            if (cfg_dec) rdata <= 2'b11;
            else if (!cfg_never && lock_n >= cfg_npolls) rdata <= 2'b01;
            else rdata <= 2'b00;
          end else if (!wstrb && address == A_SAT) begin
            rdata <= {1'b0, cfg_sat};
          end else begin
            rdata <= 2'b00;
          end
        end
      end else begin
        sl_cnt <= 0;
        ready  <= 1'b0;
        lo_run <= lo_run + 1;
        if (hi_run != 0) last_hi <= hi_run;
        hi_run <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [36:0] ent(input logic we, input logic [3:0] a, input logic [31:0] d);
    return {we, a, d};
  endfunction

  // One complete bring-up. hold >= 0 withholds ready on that access index;
  // mid_k >= 0 pulses start (with other data) while the sequence is busy.
  task automatic run_one(input int id, input logic [FCWW-1:0] f, input logic [1:0] m,
                         input int npolls, input bit never, input bit dec, input bit satv,
                         input int hld, input int mid_k);
    logic [36:0] w[5];
    logic [36:0] exp_q[$];
    int k, n, lo, hi, bad;
    bit ok;
    cfg_npolls = npolls; cfg_never = never; cfg_dec = dec; cfg_sat = satv; cfg_hold = hld;
    sl_clr = 1'b1;
    tick();
    sl_clr = 1'b0;
    fcw_in = f; mode_in = m; start = 1'b1;
    tick();
    chk($sformatf("r%0d_valid_n", id), valid, 1'b0);
    start = 1'b0; fcw_in = ~f; mode_in = ~m;
    tick();
    chk($sformatf("r%0d_valid_n1", id), valid, 1'b1);
    chk($sformatf("r%0d_busy_n1", id), busy, 1'b1);
    chk($sformatf("r%0d_first_acc", id), {wstrb, address, wdata}, ent(1'b1, A_SR, 32'd1));
    k = 0;
    while (!done && k < 3000) begin
      start = (k == mid_k);
      if (k == mid_k) fcw_in = f ^ 26'h155_5555;
      tick();
      k++;
    end
    start = 1'b0;
    chk($sformatf("r%0d_done", id), done, 1'b1);
    chk($sformatf("r%0d_busy_end", id), busy, 1'b0);
    w[0] = ent(1'b1, A_SR, 32'd1);
    w[1] = ent(1'b1, A_SR, 32'd0);
    w[2] = ent(1'b1, A_FCW, {6'd0, f});
    w[3] = ent(1'b1, A_MODE, {30'd0, m});
    w[4] = ent(1'b1, A_EN, 32'd1);
    repeat (4) tick();
    chk($sformatf("r%0d_done_once", id), dcnt, 1);
    chk($sformatf("r%0d_valid_idle", id), valid, 1'b0);
    if (hld >= 0) begin
      for (int i = 0; i < hld; i++) exp_q.push_back(w[i]);
      chk($sformatf("r%0d_flags", id), {locked, sat, err_bus, err_lock}, 4'b0010);
      chk($sformatf("r%0d_no_more_acc", id), acc_n, hld + 1);
      chk($sformatf("r%0d_req_len", id), last_hi, BUS_TO);
    end else if (dec) begin
      for (int i = 0; i < 5; i++) exp_q.push_back(w[i]);
      exp_q.push_back(ent(1'b0, A_LOCK, 32'd0));
      chk($sformatf("r%0d_flags", id), {locked, sat, err_bus, err_lock}, 4'b0010);
    end else if (never) begin
      chk($sformatf("r%0d_flags", id), {locked, sat, err_bus, err_lock}, 4'b0001);
      n = log_q.size() - 6;
      lo = LOCK_TO / (POLL_GAP + 3);
      hi = lo + 2;
      ok = (n >= lo) && (n <= hi);
      chk($sformatf("r%0d_poll_count", id), ok, 1'b1);
      bad = 0;
      for (int i = 0; i < 5 && i < log_q.size(); i++) if (log_q[i] !== w[i]) bad++;
      for (int i = 5; i < log_q.size() - 1; i++) if (log_q[i] !== ent(1'b0, A_LOCK, 32'd0)) bad++;
      chk($sformatf("r%0d_log_shape", id), bad, 0);
      if (log_q.size() > 0) chk($sformatf("r%0d_last_dis", id), log_q[log_q.size()-1], ent(1'b1, A_EN, 32'd0));
      else chk($sformatf("r%0d_last_dis", id), 37'd0, ent(1'b1, A_EN, 32'd0));
    end else begin
      for (int i = 0; i < 5; i++) exp_q.push_back(w[i]);
      for (int i = 0; i <= npolls; i++) exp_q.push_back(ent(1'b0, A_LOCK, 32'd0));
      exp_q.push_back(ent(1'b0, A_SAT, 32'd0));
      chk($sformatf("r%0d_flags", id), {locked, sat, err_bus, err_lock}, {1'b1, satv, 2'b00});
      if (npolls == 0) chk($sformatf("r%0d_latency", id), t_done - t_first, 21);
      else chk($sformatf("r%0d_poll_gap_ok", id), min_gap >= POLL_GAP + 1, 1'b1);
    end
    if (!never) begin
      chk($sformatf("r%0d_log_len", id), log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
        chk($sformatf("r%0d_log%0d", id, i), log_q[i], exp_q[i]);
    end
  endtask

  initial begin
    int sc;
    int k;
    rst = 1'b1; start = 1'b0; fcw_in = '0; mode_in = 2'b00;
    tick();
    tick();
    chk("reset_outputs", {valid, address, wdata, wstrb, busy, done, locked, sat, err_bus, err_lock}, 41'd0);
    rst = 1'b0;
    tick();

    run_one(0, 26'h2620000, 2'd2, 0, 1'b0, 1'b0, 1'b0, -1, -1);
    run_one(1, 26'h1234567, 2'd1, 3, 1'b0, 1'b0, 1'b1, -1, 4);
    run_one(2, 26'h0abcdef, 2'd3, 0, 1'b1, 1'b0, 1'b0, -1, -1);
    run_one(3, 26'h3000001, 2'd0, 0, 1'b0, 1'b0, 1'b0, 2, -1);
    run_one(4, 26'h2222222, 2'd2, 0, 1'b0, 1'b1, 1'b0, -1, -1);
    for (int r = 5; r < 13; r++) begin
      sc = $urandom_range(0, 3);
      run_one(r, FCWW'($urandom), 2'($urandom), $urandom_range(0, 5), sc == 1, sc == 3,
              1'($urandom), (sc == 2) ? $urandom_range(0, 4) : -1,
              $urandom_range(0, 1) ? $urandom_range(3, 6) : -1);
    end

    // Reset while waiting between lock polls.
    cfg_npolls = 3; cfg_never = 1'b0; cfg_dec = 1'b0; cfg_sat = 1'b1; cfg_hold = -1;
    sl_clr = 1'b1;
    tick();
    sl_clr = 1'b0;
    fcw_in = 26'h1111111; mode_in = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(lock_n >= 2 && !valid && busy) && k < 500) begin
      tick();
      k++;
    end
    chk("rst_reached_pwait", (lock_n >= 2) && !valid && busy, 1'b1);
    rst = 1'b1;
    tick();
    chk("rst_mid_outputs", {valid, address, wdata, wstrb, busy, done, locked, sat, err_bus, err_lock}, 41'd0);
    rst = 1'b0;
    repeat (30) tick();
    chk("rst_no_done", dcnt, 0);
    chk("rst_stays_idle", {valid, busy}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
